// File: rtl/vga_layer_mixer_pkg.sv
// Shared definitions for the VGA layer mixer: field widths, the black
// constant and the flash FSM state encodings.
package vga_layer_mixer_pkg;

  localparam int RGB_W    = 12;
  localparam int CNT_W    = 12;
  localparam int OVL_W    = 16;
  // hcount, vcount, hsync, vsync, hblnk, vblnk
  localparam int TIMING_W = 2 * CNT_W + 4;

  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_ARM   = 2'd1,
    FL_FLASH = 2'd2
  } flash_state_t;

endpackage

// File: rtl/vga_layer_mixer_pipe_delay.sv
// pipe_delay: fixed-depth register chain with synchronous clear.
// DEPTH of 0 degenerates to a wire so the mixer can run with a single stage.
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_dly
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift register; every stage clears together on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: fixed-priority layer compositor with frame-synchronous
// enable mask, per-frame collision counting and an optional damage flash.
// The flash FSM is built only when VGA_LAYER_MIXER_FLASH_EN is defined.
module vga_layer_mixer
  import vga_layer_mixer_pkg::*;
#(
  parameter int               NUM_LAYERS   = 4,
  parameter int               PIPE_STAGES  = 2,
  parameter logic [RGB_W-1:0] BG_RGB       = 12'h000,
  parameter int               COLLIDE_A    = 0,
  parameter int               COLLIDE_B    = 1,
  parameter int               FLASH_FRAMES = 8,
  parameter logic [RGB_W-1:0] FLASH_RGB    = 12'hF00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CNT_W-1:0]            hcount_in,
  input  logic [CNT_W-1:0]            vcount_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        hblnk_in,
  input  logic                        vblnk_in,
  input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb_in,
  input  logic [NUM_LAYERS-1:0]       layer_valid_in,
  input  logic [NUM_LAYERS-1:0]       layer_en_in,
  input  logic                        hit_in,
  output logic [CNT_W-1:0]            hcount_out,
  output logic [CNT_W-1:0]            vcount_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic [RGB_W-1:0]            rgb_out,
  output logic [NUM_LAYERS-1:0]       layer_en_active,
  output logic                        collision_out,
  output logic [OVL_W-1:0]            overlap_count_out,
  output logic                        flash_active
);

  function automatic logic [OVL_W-1:0] sat_inc(input logic [OVL_W-1:0] v);
    return (v == {OVL_W{1'b1}}) ? v : v + 16'd1;
  endfunction

  logic                  vsync_q;
  logic                  fe;
  logic                  active_vid;
  logic                  ovl_pix;
  logic                  flash_pix;
  logic [OVL_W-1:0]      ovl_cnt;
  logic [NUM_LAYERS-1:0] layer_qual;
  logic [RGB_W-1:0]      pix_rgb;

  assign fe         = vsync_in & ~vsync_q;
  assign active_vid = ~(hblnk_in | vblnk_in);
  assign layer_qual = layer_valid_in & layer_en_active;
  assign ovl_pix    = active_vid & layer_qual[COLLIDE_A] & layer_qual[COLLIDE_B];

  // Frame-edge bookkeeping: mask latch, collision count and report.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q           <= 1'b1;
      layer_en_active   <= '1;
      ovl_cnt           <= '0;
      overlap_count_out <= '0;
      collision_out     <= 1'b0;
    end else begin
      vsync_q       <= vsync_in;
      collision_out <= 1'b0;
      if (fe) begin
        layer_en_active   <= layer_en_in;
        overlap_count_out <= ovl_cnt;
        collision_out     <= (ovl_cnt != '0);
        ovl_cnt           <= '0;
      end else if (ovl_pix) begin
        ovl_cnt <= sat_inc(ovl_cnt);
      end
    end
  end

`ifdef VGA_LAYER_MIXER_FLASH_EN
  flash_state_t fl_state, fl_state_nx;
  logic [7:0]   frame_cnt, frame_cnt_nx;

  // Flash FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_state  <= FL_IDLE;
      frame_cnt <= '0;
    end else begin
      fl_state  <= fl_state_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  // Flash FSM next state; a hit during FLASH re-arms and restarts the count.
  always_comb begin
    fl_state_nx  = fl_state;
    frame_cnt_nx = frame_cnt;
    case (fl_state)
      FL_IDLE: begin
        if (hit_in) fl_state_nx = FL_ARM;
      end
      FL_ARM: begin
        if (fe) begin
          fl_state_nx  = FL_FLASH;
          frame_cnt_nx = 8'(FLASH_FRAMES);
        end
      end
      FL_FLASH: begin
        if (hit_in) begin
          fl_state_nx = FL_ARM;
        end else if (fe) begin
          frame_cnt_nx = frame_cnt - 8'd1;
          if (frame_cnt_nx == 8'd0) fl_state_nx = FL_IDLE;
        end
      end
      default: fl_state_nx = FL_IDLE;
    endcase
  end

  assign flash_active = (fl_state == FL_FLASH);
  assign flash_pix    = flash_active & frame_cnt[0];
`else
  logic unused_hit;
  assign unused_hit   = hit_in;
  assign flash_active = 1'b0;
  assign flash_pix    = 1'b0;
`endif

  // Priority select: scan high to low so the lowest qualifying index wins.
  always_comb begin
    pix_rgb = BG_RGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_qual[i]) pix_rgb = layer_rgb_in[RGB_W*i +: RGB_W];
    end
    if (flash_pix) pix_rgb = FLASH_RGB;
    if (!active_vid) pix_rgb = RGB_BLACK;
  end

  // ---- stage 1: registered selection and timing ----
  logic [TIMING_W-1:0] timing_p1;
  logic [RGB_W-1:0]    rgb_p1;

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timing_p1 <= '0;
      rgb_p1    <= '0;
    end else begin
      timing_p1 <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      rgb_p1    <= pix_rgb;
    end
  end

  // ---- stages 2..PIPE_STAGES: pure delay ----
  logic [TIMING_W+RGB_W-1:0] dly_out;

  pipe_delay #(
    .WIDTH(TIMING_W + RGB_W),
    .DEPTH(PIPE_STAGES - 1)
  ) u_pipe_delay (
    .clk (clk),
    .rst (rst),
    .din ({timing_p1, rgb_p1}),
    .dout(dly_out)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out,
          hblnk_out, vblnk_out, rgb_out} = dly_out;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed self-checking bench for vga_layer_mixer (4 layers, 2 stages,
// BG_RGB=12'h123, FLASH_FRAMES=4).
module tb_vga_layer_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [47:0] layer_rgb_in;
  logic [3:0]  layer_valid_in, layer_en_in;
  logic        hit_in;
  logic [11:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [3:0]  layer_en_active;
  logic        collision_out;
  logic [15:0] overlap_count_out;
  logic        flash_active;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_layer_mixer #(
    .NUM_LAYERS(4), .PIPE_STAGES(2), .BG_RGB(12'h123),
    .COLLIDE_A(0), .COLLIDE_B(1), .FLASH_FRAMES(4), .FLASH_RGB(12'hF00)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .layer_rgb_in(layer_rgb_in), .layer_valid_in(layer_valid_in),
    .layer_en_in(layer_en_in), .hit_in(hit_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .layer_en_active(layer_en_active),
    .collision_out(collision_out), .overlap_count_out(overlap_count_out),
    .flash_active(flash_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [11:0] h, input logic [11:0] v, input logic [3:0] vld);
    hcount_in = h; vcount_in = v;
    hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    layer_valid_in = vld;
  endtask

  task automatic fe_start();
    hblnk_in = 1'b1; vblnk_in = 1'b1;
    layer_valid_in = 4'b0000;
    vsync_in = 1'b1;
  endtask

  task automatic do_fe();
    fe_start();
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pix(12'd5, 12'd5, 4'b0101);
    tick(); tick(); tick();
    n_cmp++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got=%h want=%h", rgb_out, 12'h000); end
    n_cmp++; if (hcount_out !== 12'd0) begin n_fail++; $display("FAIL reset_hcount got=%0d want=0", hcount_out); end
    n_cmp++; if (layer_en_active !== 4'hF) begin n_fail++; $display("FAIL reset_mask got=%b want=1111", layer_en_active); end
    n_cmp++; if (collision_out !== 1'b0 || overlap_count_out !== 16'd0) begin n_fail++; $display("FAIL reset_coll got=%b/%0d want=0/0", collision_out, overlap_count_out); end
    n_cmp++; if (flash_active !== 1'b0) begin n_fail++; $display("FAIL reset_flash got=%b want=0", flash_active); end
    rst = 1'b0;
  endtask

  task automatic test_priority();
    set_pix(12'd100, 12'd100, 4'b0101);
    tick();
    n_cmp++; if (hcount_out !== 12'd0) begin n_fail++; $display("FAIL prio_latency hcount got=%0d want=0", hcount_out); end
    tick();
    n_cmp++; if (rgb_out !== 12'hA01) begin n_fail++; $display("FAIL prio_l0 got=%h want=%h", rgb_out, 12'hA01); end
    n_cmp++; if (hcount_out !== 12'd100 || vcount_out !== 12'd100) begin n_fail++; $display("FAIL prio_hv got=%0d,%0d want=100,100", hcount_out, vcount_out); end
    set_pix(12'd101, 12'd100, 4'b1000);
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'hD04) begin n_fail++; $display("FAIL prio_l3 got=%h want=%h", rgb_out, 12'hD04); end
    set_pix(12'd102, 12'd100, 4'b1010);
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'hB02) begin n_fail++; $display("FAIL prio_l1 got=%h want=%h", rgb_out, 12'hB02); end
  endtask

  task automatic test_mask();
    layer_en_in = 4'b1110;
    set_pix(12'd110, 12'd100, 4'b0101);
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'hA01) begin n_fail++; $display("FAIL mask_midframe got=%h want=%h", rgb_out, 12'hA01); end
    n_cmp++; if (layer_en_active !== 4'hF) begin n_fail++; $display("FAIL mask_hold got=%b want=1111", layer_en_active); end
    fe_start();
    tick();
    n_cmp++; if (layer_en_active !== 4'hE) begin n_fail++; $display("FAIL mask_latch got=%b want=1110", layer_en_active); end
    vsync_in = 1'b0;
    tick();
    set_pix(12'd10, 12'd0, 4'b0101);
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'hC03) begin n_fail++; $display("FAIL mask_newframe got=%h want=%h", rgb_out, 12'hC03); end
  endtask

  task automatic test_blank();
    set_pix(12'd200, 12'd0, 4'b0000);
    hblnk_in = 1'b1;
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'h000 || hblnk_out !== 1'b1) begin n_fail++; $display("FAIL blank_h got=%h/%b want=000/1", rgb_out, hblnk_out); end
    set_pix(12'd20, 12'd480, 4'b0101);
    vblnk_in = 1'b1;
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL blank_v_valid got=%h want=000", rgb_out); end
    set_pix(12'd20, 12'd20, 4'b0000);
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'h123) begin n_fail++; $display("FAIL bg got=%h want=%h", rgb_out, 12'h123); end
  endtask

  task automatic test_collision();
    layer_en_in = 4'hF;
    do_fe();
    n_cmp++; if (layer_en_active !== 4'hF) begin n_fail++; $display("FAIL coll_mask got=%b want=1111", layer_en_active); end
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        set_pix(12'(300 + x), 12'(50 + y), 4'b0011);
        tick();
      end
    set_pix(12'd310, 12'd50, 4'b0001); tick();
    set_pix(12'd311, 12'd50, 4'b0010); tick();
    set_pix(12'd312, 12'd50, 4'b0011); hblnk_in = 1'b1; tick();
    fe_start();
    tick();
    n_cmp++; if (collision_out !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got=%b want=1", collision_out); end
    n_cmp++; if (overlap_count_out !== 16'd16) begin n_fail++; $display("FAIL coll_count got=%0d want=16", overlap_count_out); end
    vsync_in = 1'b0;
    tick();
    n_cmp++; if (collision_out !== 1'b0 || overlap_count_out !== 16'd16) begin n_fail++; $display("FAIL coll_onecycle got=%b/%0d want=0/16", collision_out, overlap_count_out); end
    set_pix(12'd300, 12'd50, 4'b0101); tick();
    set_pix(12'd301, 12'd50, 4'b0010); tick();
    fe_start();
    tick();
    n_cmp++; if (collision_out !== 1'b0 || overlap_count_out !== 16'd0) begin n_fail++; $display("FAIL coll_none got=%b/%0d want=0/0", collision_out, overlap_count_out); end
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic test_flash();
    set_pix(12'd5, 12'd5, 4'b0000);
    hit_in = 1'b1; tick(); hit_in = 1'b0;
`ifdef VGA_LAYER_MIXER_FLASH_EN
    n_cmp++; if (flash_active !== 1'b0) begin n_fail++; $display("FAIL flash_arm got=%b want=0", flash_active); end
    tick(); tick();
    n_cmp++; if (rgb_out !== 12'h123) begin n_fail++; $display("FAIL flash_arm_rgb got=%h want=123", rgb_out); end
    fe_start(); tick();
    n_cmp++; if (flash_active !== 1'b1) begin n_fail++; $display("FAIL flash_start got=%b want=1", flash_active); end
    vsync_in = 1'b0; tick();
    set_pix(12'd5, 12'd5, 4'b0001); tick(); tick();
    n_cmp++; if (rgb_out !== 12'hA01) begin n_fail++; $display("FAIL flash_cnt4_rgb got=%h want=A01", rgb_out); end
    do_fe();
    set_pix(12'd5, 12'd5, 4'b0001); tick(); tick();
    n_cmp++; if (rgb_out !== 12'hF00) begin n_fail++; $display("FAIL flash_cnt3_rgb got=%h want=F00", rgb_out); end
    hblnk_in = 1'b1; tick(); tick();
    n_cmp++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL flash_blank got=%h want=000", rgb_out); end
    do_fe();
    set_pix(12'd5, 12'd5, 4'b0000);
    hit_in = 1'b1; tick(); hit_in = 1'b0;
    n_cmp++; if (flash_active !== 1'b0) begin n_fail++; $display("FAIL flash_rearm got=%b want=0", flash_active); end
    do_fe();
    n_cmp++; if (flash_active !== 1'b1) begin n_fail++; $display("FAIL flash_restart got=%b want=1", flash_active); end
    do_fe(); do_fe(); do_fe();
    n_cmp++; if (flash_active !== 1'b1) begin n_fail++; $display("FAIL flash_last_frame got=%b want=1", flash_active); end
    set_pix(12'd5, 12'd5, 4'b0000); tick(); tick();
    n_cmp++; if (rgb_out !== 12'hF00) begin n_fail++; $display("FAIL flash_cnt1_rgb got=%h want=F00", rgb_out); end
    do_fe();
    n_cmp++; if (flash_active !== 1'b0) begin n_fail++; $display("FAIL flash_end got=%b want=0", flash_active); end
`else
    do_fe();
    n_cmp++; if (flash_active !== 1'b0) begin n_fail++; $display("FAIL noflash_active got=%b want=0", flash_active); end
    set_pix(12'd5, 12'd5, 4'b0000); tick(); tick();
    n_cmp++; if (rgb_out !== 12'h123) begin n_fail++; $display("FAIL noflash_rgb got=%h want=123", rgb_out); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 50; i++) begin
      set_pix(12'(i), 12'd60, 4'b0011); tick();
    end
    fe_start(); tick();
    n_cmp++; if (overlap_count_out !== 16'd50) begin n_fail++; $display("FAIL rmid_count50 got=%0d want=50", overlap_count_out); end
    vsync_in = 1'b0; tick();
    layer_en_in = 4'b0111;
    for (int i = 0; i < 50; i++) begin
      set_pix(12'(i), 12'd61, 4'b0011); tick();
    end
    rst = 1'b1;
    fe_start();
    hcount_in = 12'd7;
    tick();
    n_cmp++; if (rgb_out !== 12'h000 || hcount_out !== 12'd0) begin n_fail++; $display("FAIL rmid_pipe got=%h/%0d want=000/0", rgb_out, hcount_out); end
    n_cmp++; if (collision_out !== 1'b0 || overlap_count_out !== 16'd0) begin n_fail++; $display("FAIL rmid_coll got=%b/%0d want=0/0", collision_out, overlap_count_out); end
    n_cmp++; if (layer_en_active !== 4'hF || flash_active !== 1'b0) begin n_fail++; $display("FAIL rmid_mask got=%b/%b want=1111/0", layer_en_active, flash_active); end
    rst = 1'b0;
    tick();
    n_cmp++; if (layer_en_active !== 4'hF) begin n_fail++; $display("FAIL rmid_no_spurious_fe got=%b want=1111", layer_en_active); end
    vsync_in = 1'b0; tick();
    fe_start(); tick();
    n_cmp++; if (collision_out !== 1'b0 || overlap_count_out !== 16'd0) begin n_fail++; $display("FAIL rmid_first_fe got=%b/%0d want=0/0", collision_out, overlap_count_out); end
    n_cmp++; if (layer_en_active !== 4'b0111) begin n_fail++; $display("FAIL rmid_mask_fe got=%b want=0111", layer_en_active); end
    vsync_in = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    layer_rgb_in = {12'hD04, 12'hC03, 12'hB02, 12'hA01};
    layer_valid_in = '0;
    layer_en_in = 4'hF;
    hit_in = 1'b0;
    test_reset();
    test_priority();
    test_mask();
    test_blank();
    test_collision();
    test_flash();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
